// File: rtl/uart_rx_frame_engine_if.sv
// Receive-side result bundle of the UART frame engine: character strobe, data and status flags.
// The engine drives it through the master modport; consumers use the slave modport.
interface uart_rx_frame_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  parity_error;
  logic                  frame_error;
  logic                  break_detect;
  logic                  rx_busy;

  modport master (
    output rx_valid, rx_data, parity_error, frame_error, break_detect, rx_busy
  );

  modport slave (
    input rx_valid, rx_data, parity_error, frame_error, break_detect, rx_busy
  );
endinterface

// File: rtl/uart_rx_frame_engine.sv
// Oversampling UART receiver: synchronises the line, frames start/data/parity/stop bits and
// reports each character with parity, framing and break status on a one-cycle strobe.
module uart_rx_frame_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     baud_tick,
  input  logic                     rx_enable,
  input  logic                     uart_rxd,
  input  logic                     loop,
  input  logic                     loop_txd,
  input  logic [4:0]               char_len,
  input  logic                     pen,
  input  logic                     eps,
  input  logic                     sp,
  uart_rx_frame_engine_if.master   rx_if
);

  localparam int             CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]  HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t                  state_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [CW-1:0]           cnt_q;
  logic [4:0]              bit_q;
  logic [4:0]              len_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_q;
  logic                    perr_q;
  logic                    zero_q;
  logic                    rx_valid_q;
  logic [DATA_WIDTH-1:0]   rx_data_q;
  logic                    parity_error_q;
  logic                    frame_error_q;
  logic                    break_detect_q;
  logic                    rx_busy_q;

  logic                    serial_in_s;
  logic [4:0]              len_s;
  logic                    exp_par_s;

  // Metastability synchroniser for the external line; idles high like the line itself
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
    end
  end

  // Source select, character length clamp and expected parity bit
  always_comb begin
    serial_in_s = loop ? loop_txd : sync_q[SYNC_STAGES-1];
    if (char_len < 5'd5) begin
      len_s = 5'd5;
    end else if (char_len > 5'(DATA_WIDTH)) begin
      len_s = 5'(DATA_WIDTH);
    end else begin
      len_s = char_len;
    end
    if (sp) begin
      exp_par_s = ~eps;
    end else if (eps) begin
      exp_par_s = par_q;
    end else begin
      exp_par_s = ~par_q;
    end
  end

  // Frame FSM with datapath and registered result outputs
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bit_q          <= 5'd0;
      len_q          <= 5'd0;
      data_q         <= '0;
      par_q          <= 1'b0;
      perr_q         <= 1'b0;
      zero_q         <= 1'b0;
      rx_valid_q     <= 1'b0;
      rx_data_q      <= '0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      break_detect_q <= 1'b0;
      rx_busy_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if ((state_q != IDLE) && !rx_enable) begin
        state_q   <= IDLE;
        rx_busy_q <= 1'b0;
      end else if (baud_tick) begin
        case (state_q)
          IDLE: begin
            if (rx_enable && !serial_in_s) begin
              state_q   <= START;
              cnt_q     <= '0;
              len_q     <= len_s;
              rx_busy_q <= 1'b1;
            end
          end
          START: begin
            if (cnt_q == HALF_M1) begin
              cnt_q <= '0;
              if (!serial_in_s) begin
                state_q <= DATA;
                bit_q   <= 5'd0;
                data_q  <= '0;
                par_q   <= 1'b0;
                perr_q  <= 1'b0;
                zero_q  <= 1'b1;
              end else begin
                state_q   <= IDLE;
                rx_busy_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          DATA: begin
            if (cnt_q == FULL_M1) begin
              cnt_q  <= '0;
              data_q <= data_q | ({{(DATA_WIDTH-1){1'b0}}, serial_in_s} << bit_q);
              par_q  <= par_q ^ serial_in_s;
              zero_q <= zero_q & ~serial_in_s;
              bit_q  <= bit_q + 5'd1;
              if (bit_q == (len_q - 5'd1)) begin
                state_q <= pen ? PARITY : STOP;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          PARITY: begin
            if (cnt_q == FULL_M1) begin
              cnt_q   <= '0;
              perr_q  <= (serial_in_s != exp_par_s);
              zero_q  <= zero_q & ~serial_in_s;
              state_q <= STOP;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          STOP: begin
            if (cnt_q == FULL_M1) begin
              cnt_q          <= '0;
              rx_valid_q     <= 1'b1;
              rx_data_q      <= data_q;
              parity_error_q <= perr_q;
              frame_error_q  <= ~serial_in_s;
              break_detect_q <= zero_q & ~serial_in_s;
              // A low stop bit may be the start of a break: wait for the line to recover
              state_q        <= serial_in_s ? IDLE : WAIT_IDLE;
              rx_busy_q      <= ~serial_in_s;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          WAIT_IDLE: begin
            if (serial_in_s) begin
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end
          end
          default: begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_if.rx_valid     = rx_valid_q;
  assign rx_if.rx_data      = rx_data_q;
  assign rx_if.parity_error = parity_error_q;
  assign rx_if.frame_error  = frame_error_q;
  assign rx_if.break_detect = break_detect_q;
  assign rx_if.rx_busy      = rx_busy_q;

endmodule

// File: doc/uart_rx_frame_engine.md
UART_RX_FRAME_ENGINE -- requirements
Module: uart_rx_frame_engine

Interface
REQ-001 Parameters SHALL be:
  - DATA_WIDTH, default 8, maximum character length, legal 5..16
  - OVERSAMPLE, default 16, baud ticks per bit, even, at least 4
  - SYNC_STAGES, default 2, uart_rxd synchroniser depth, at least 2
REQ-002 Ports SHALL be:
  - pclk  in  1  sole clock, rising edge
  - presetn  in  1  asynchronous, active-low reset
  - baud_tick  in  1  oversample enable, one pclk pulse per tick
  - rx_enable  in  1  receiver enable
  - uart_rxd  in  1  serial line, asynchronous
  - loop  in  1  loopback select
  - loop_txd  in  1  transmitter output, pclk-synchronous
  - char_len  in  5  data bits per character
  - pen  in  1  parity enable
  - eps  in  1  even parity select
  - sp  in  1  stick parity
  - rx_valid  out  1  one-cycle character strobe
  - rx_data  out  DATA_WIDTH  received character
  - parity_error  out  1  parity error for rx_data
  - frame_error  out  1  stop-bit error for rx_data
  - break_detect  out  1  break condition for rx_data
  - rx_busy  out  1  frame in progress

Function
REQ-003 uart_rxd SHALL pass through SYNC_STAGES flops; serial_in = loop ? loop_txd : synchronised uart_rxd, with no synchroniser on loop_txd.
REQ-004 char_len SHALL be sampled at START entry and held for the frame; values below 5 act as 5 and values above DATA_WIDTH act as DATA_WIDTH.
REQ-005 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE, advancing only on baud_tick cycles.
REQ-006 IDLE SHALL go to START, clearing the tick counter, on a baud_tick with serial_in==0 and rx_enable==1.
REQ-007 START SHALL sample serial_in at tick OVERSAMPLE/2-1: value 0 goes to DATA, value 1 (glitch) returns to IDLE with no rx_valid.
REQ-008 DATA, PARITY and STOP SHALL each sample once per OVERSAMPLE ticks after the start sample (mid-bit).
REQ-009 DATA bits SHALL be LSB first, right-justified in rx_data, with bits above char_len zero.
REQ-010 PARITY SHALL be entered only when pen==1, otherwise DATA goes directly to STOP.
REQ-011 Expected parity SHALL be:
  - sp==1: ~eps
  - sp==0, eps==1: XOR of data bits
  - sp==0, eps==0: inverse of XOR of data bits
  - parity_error = sampled parity bit != expected parity bit.
REQ-012 Only the first stop bit SHALL be checked; frame_error = stop sample==0.
REQ-013 break_detect SHALL be 1 when all data, parity and stop samples are 0.
REQ-014 rx_valid SHALL pulse high for exactly one pclk cycle, the cycle after the stop-sample tick.
REQ-015 rx_data, parity_error, frame_error and break_detect SHALL update in the rx_valid cycle and hold until the next rx_valid.
REQ-016 After STOP:
  - stop sample 1: return to IDLE
  - stop sample 0: go to WAIT_IDLE, which returns to IDLE on the first baud_tick with serial_in==1.
REQ-017 rx_busy SHALL be 1 in START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-018 Deasserting rx_enable outside IDLE SHALL abort to IDLE on the next pclk edge, with no rx_valid and flags unchanged.
REQ-019 A loop change mid-frame SHALL NOT abort the frame; later samples take the new source.
REQ-020 baud_tick low SHALL freeze the counter and FSM.

Reset
REQ-021 presetn==0 SHALL asynchronously force:
  - all outputs to 0
  - FSM to IDLE, counters to 0
  - synchroniser flops to 1
REQ-022 Release of presetn SHALL take effect synchronously to pclk, and a frame in progress at reset SHALL be discarded with no rx_valid.

Verification (OVERSAMPLE=16, baud_tick=1 every cycle)
REQ-023 The bench SHALL cover these directed scenarios:
  - 8N1, 0xA5 -> exactly one rx_valid, rx_data=0xA5, all flags 0, strobe 8+9x16+1 cycles after START entry.
  - char_len=7, pen=1, eps=1, data 0x35 with parity bit 1 (wrong) -> rx_data=0x0035, parity_error=1, frame_error=0.
  - sp=1, eps=0, parity bit 1 -> parity_error=0; same frame with parity bit 0 -> parity_error=1.
  - 8N1, 0x5A with stop bit 0, line then high -> frame_error=1, break_detect=0, WAIT_IDLE 1 tick, next frame received.
  - Line held low 300 cycles -> one rx_valid, rx_data=0, frame_error=1, break_detect=1, no further rx_valid until line high, then normal frame.
  - Start pulse low for 4 ticks -> no rx_valid, rx_busy falls after sample at tick 7.
  - loop=1, uart_rxd stuck 0, loop_txd sends 0x3C -> rx_data=0x3C, no errors.
  - presetn low at DATA bit 3 -> outputs 0 immediately, no rx_valid, next frame 0x81 received cleanly.
